dqs_wr_gen: RTL and testbench

DQS_WR_GEN -- requirements
Module: dqs_wr_gen

---
 rtl/dqs_wr_gen.sv | 98 +++++++++
 tb/tb_dqs_wr_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dqs_wr_gen.sv
// dqs_wr_gen: DDR write DQS pattern generator (preamble, BL8 bursts, postamble).
// Ports:
//   pclk     - parallel clock, the only clock
//   rst_n    - asynchronous active-low reset
//   wr_start - single-cycle write request
//   wr_len   - number of BL8 bursts, sampled with wr_start (0 means 16)
//   dqs_pat  - 8-bit DQS pattern for the 8:1 serializer, bit 0 leaves first
//   dqs_oe   - DQS pad drive enable
//   data_en  - high on cycles carrying a BL8 data burst
//   busy     - high whenever the FSM is not idle
//   done     - one-cycle pulse on the final postamble cycle
module dqs_wr_gen #(
   parameter int PRE_CYC  = 1,
   parameter int POST_CYC = 1
) (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic       wr_start,
   input  logic [3:0] wr_len,
   output logic [7:0] dqs_pat,
   output logic       dqs_oe,
   output logic       data_en,
   output logic       busy,
   output logic       done
);
   typedef enum logic [1:0] {IDLE, PRE, BURST, POST} state_t;

   localparam logic [1:0] PRE_LD  = 2'(PRE_CYC);
   localparam logic [1:0] POST_LD = 2'(POST_CYC);

   state_t     state, state_nx;
   logic [4:0] cnt, cnt_nx;
   logic [1:0] pp, pp_nx;
   logic [4:0] len_ld;
   logic       armed;
   logic       start;

   // armed stays low for the first edge after reset release so a request
   // coincident with that edge is dropped.
   assign len_ld = (wr_len == 4'd0) ? 5'd16 : {1'b0, wr_len};
   assign start  = wr_start & armed;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pp_nx    = pp;
      unique case (state)
         IDLE: if (start) begin
            state_nx = PRE;
            cnt_nx   = len_ld;
            pp_nx    = PRE_LD;
         end
         PRE: begin
            state_nx = (pp == 2'd1) ? BURST : PRE;
            pp_nx    = pp - 2'd1;
         end
         BURST: if (cnt == 5'd1) begin
            // last burst: a new request chains seamlessly, otherwise postamble
            state_nx = start ? BURST : POST;
            cnt_nx   = start ? len_ld : cnt;
            pp_nx    = start ? pp : POST_LD;
         end else begin
            cnt_nx = cnt - 5'd1;
         end
         POST: begin
            state_nx = (pp == 2'd1) ? IDLE : POST;
            pp_nx    = pp - 2'd1;
         end
         default: state_nx = IDLE;
      endcase
   end

   // outputs are registered from the next state so they describe the
   // state the FSM is in during the following cycle
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         pp      <= '0;
         armed   <= 1'b0;
         dqs_pat <= 8'h00;
         dqs_oe  <= 1'b0;
         data_en <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         pp      <= pp_nx;
         armed   <= 1'b1;
         dqs_pat <= (state_nx == BURST) ? 8'h55 : 8'h00;
         dqs_oe  <= state_nx != IDLE;
         data_en <= state_nx == BURST;
         busy    <= state_nx != IDLE;
         done    <= (state_nx == POST) && (pp_nx == 2'd1);
      end
   end
endmodule

// File: tb/tb_dqs_wr_gen.sv
// tb_dqs_wr_gen: directed bench for dqs_wr_gen with default and 2/3 pre/post instances.
module tb_dqs_wr_gen;
   localparam logic [11:0] V_IDLE = 12'h000;
   localparam logic [11:0] V_PRE  = 12'h900;
   localparam logic [11:0] V_BST  = 12'hB55;
   localparam logic [11:0] V_POST = 12'h900;
   localparam logic [11:0] V_DONE = 12'hD00;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ws0 = 1'b0, ws1 = 1'b0;
   logic [3:0] len0 = '0, len1 = '0;
   logic [7:0] pat0, pat1;
   logic       oe0, de0, busy0, done0, oe1, de1, busy1, done1;
   int         total = 0;
   int         passed = 0;

   always #5 clk = ~clk;

   dqs_wr_gen u0 (
      .pclk(clk), .rst_n(rst_n), .wr_start(ws0), .wr_len(len0),
      .dqs_pat(pat0), .dqs_oe(oe0), .data_en(de0), .busy(busy0), .done(done0)
   );

   dqs_wr_gen #(.PRE_CYC(2), .POST_CYC(3)) u1 (
      .pclk(clk), .rst_n(rst_n), .wr_start(ws1), .wr_len(len1),
      .dqs_pat(pat1), .dqs_oe(oe1), .data_en(de1), .busy(busy1), .done(done1)
   );

   wire [11:0] obs0 = {busy0, done0, de0, oe0, pat0};
   wire [11:0] obs1 = {busy1, done1, de1, oe1, pat1};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 chk("reset_async", obs0, V_IDLE);
      tick();
      chk("reset_u0", obs0, V_IDLE);
      chk("reset_u1", obs1, V_IDLE);
      // request on the release edge must be ignored
      #2 rst_n = 1'b1; ws0 = 1'b1; len0 = 4'd1;
      tick(); ws0 = 1'b0;
      chk("release_ignored", obs0, V_IDLE);
      tick();
      chk("idle_hold", obs0, V_IDLE);

      // single burst
      ws0 = 1'b1; len0 = 4'd1;
      tick(); ws0 = 1'b0;
      chk("s1_pre", obs0, V_PRE);
      tick(); chk("s1_burst", obs0, V_BST);
      tick(); chk("s1_post_done", obs0, V_DONE);
      tick(); chk("s1_idle", obs0, V_IDLE);

      // length 0 means 16 bursts
      ws0 = 1'b1; len0 = 4'd0;
      tick(); ws0 = 1'b0;
      chk("s2_pre", obs0, V_PRE);
      for (int i = 0; i < 16; i++) begin
         tick(); chk($sformatf("s2_burst%0d", i), obs0, V_BST);
      end
      tick(); chk("s2_post_done", obs0, V_DONE);
      tick(); chk("s2_idle", obs0, V_IDLE);

      // chained write 2 + 3
      ws0 = 1'b1; len0 = 4'd2;
      tick(); ws0 = 1'b0;
      chk("s3_pre", obs0, V_PRE);
      tick(); chk("s3_b0", obs0, V_BST);
      tick(); chk("s3_b1", obs0, V_BST);
      ws0 = 1'b1; len0 = 4'd3;
      for (int i = 2; i < 5; i++) begin
         tick(); ws0 = 1'b0; chk($sformatf("s3_b%0d", i), obs0, V_BST);
      end
      tick(); chk("s3_post_done", obs0, V_DONE);
      tick(); chk("s3_idle", obs0, V_IDLE);

      // requests in PRE and non-last BURST are ignored
      ws0 = 1'b1; len0 = 4'd4;
      tick(); ws0 = 1'b0;
      chk("s4_pre", obs0, V_PRE);
      ws0 = 1'b1; len0 = 4'd1;
      tick(); ws0 = 1'b0;
      chk("s4_b0", obs0, V_BST);
      ws0 = 1'b1; len0 = 4'd1;
      tick(); ws0 = 1'b0;
      chk("s4_b1", obs0, V_BST);
      tick(); chk("s4_b2", obs0, V_BST);
      tick(); chk("s4_b3", obs0, V_BST);
      tick(); chk("s4_post_done", obs0, V_DONE);
      tick(); chk("s4_idle", obs0, V_IDLE);
      tick(); chk("s4_no_extra", obs0, V_IDLE);

      // PRE_CYC=2, POST_CYC=3
      ws1 = 1'b1; len1 = 4'd1;
      tick(); ws1 = 1'b0;
      chk("s5_pre0", obs1, V_PRE);
      tick(); chk("s5_pre1", obs1, V_PRE);
      tick(); chk("s5_burst", obs1, V_BST);
      tick(); chk("s5_post0", obs1, V_POST);
      tick(); chk("s5_post1", obs1, V_POST);
      tick(); chk("s5_post2_done", obs1, V_DONE);
      tick(); chk("s5_idle", obs1, V_IDLE);

      // asynchronous reset mid-burst
      ws0 = 1'b1; len0 = 4'd4;
      tick(); ws0 = 1'b0;
      chk("s6_pre", obs0, V_PRE);
      tick(); chk("s6_burst", obs0, V_BST);
      #2 rst_n = 1'b0;
      #1 chk("s6_async_clear", obs0, V_IDLE);
      for (int i = 0; i < 5; i++) begin
         tick(); chk($sformatf("s6_no_done%0d", i), obs0, V_IDLE);
      end
      #2 rst_n = 1'b1;
      tick(); chk("s6_released", obs0, V_IDLE);
      ws0 = 1'b1; len0 = 4'd1;
      tick(); ws0 = 1'b0;
      chk("s6_pre", obs0, V_PRE);
      tick(); chk("s6_b", obs0, V_BST);
      tick(); chk("s6_post_done", obs0, V_DONE);
      tick(); chk("s6_idle", obs0, V_IDLE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
